// File: rtl/axis_bp_shaper.sv
// Multi-channel AXI-Stream backpressure shaper: per-channel bypass/random/periodic/halt
// gating of valid/ready with protocol-safe locking and saturating stall counters.
module axis_bp_shaper #(
    parameter int          NUM_CH = 8,
    parameter logic [31:0] SEED   = 32'hb105f00d,
    parameter int          CNT_W  = 16,
    parameter int          STAT_W = 32
) (
    input  logic                      user_clk,
    input  logic                      user_reset,
    input  logic [2*NUM_CH-1:0]       mode,
    input  logic [8*NUM_CH-1:0]       thresh,
    input  logic [CNT_W*NUM_CH-1:0]   on_cnt,
    input  logic [CNT_W*NUM_CH-1:0]   off_cnt,
    input  logic                      stat_clr,
    input  logic [NUM_CH-1:0]         valid_i,
    input  logic [NUM_CH-1:0]         ready_i,
    output logic [NUM_CH-1:0]         valid_o,
    output logic [NUM_CH-1:0]         ready_o,
    output logic [STAT_W*NUM_CH-1:0]  stall_cnt
);

    localparam logic [1:0]  MODE_BYP  = 2'b00;
    localparam logic [1:0]  MODE_RND  = 2'b01;
    localparam logic [1:0]  MODE_PER  = 2'b10;
    localparam logic [1:0]  MODE_HALT = 2'b11;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] GOLDEN    = 32'h9E37_79B9;

    // Right-shifting Galois step for x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

    // Per-channel seed; an all-zero result would lock the LFSR, so fall back to SEED.
    function automatic logic [31:0] chan_seed(input int c);
        logic [31:0] x;
        x = SEED ^ (32'(c) * GOLDEN);
        return (x == 32'h0000_0000) ? SEED : x;
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [1:0]        mode_s;
        logic [7:0]        thr_s;
        logic [CNT_W-1:0]  on_s;
        logic [CNT_W-1:0]  off_s;
        logic [1:0]        mode_q;
        logic [31:0]       lfsr_q;
        logic [31:0]       lfsr_d;
        logic              phase_q;
        logic              phase_d;
        logic [CNT_W-1:0]  cnt_q;
        logic [CNT_W-1:0]  cnt_d;
        logic              lock_q;
        logic              lock_d;
        logic [STAT_W-1:0] stall_q;
        logic [STAT_W-1:0] stall_d;
        logic              eff_phase_s;
        logic [CNT_W-1:0]  eff_cnt_s;
        logic              raw_s;
        logic              allow_s;
        logic              inc_s;

        assign mode_s = mode[2*c +: 2];
        assign thr_s  = thresh[8*c +: 8];
        assign on_s   = on_cnt[CNT_W*c +: CNT_W];
        assign off_s  = off_cnt[CNT_W*c +: CNT_W];

        // A mode change makes the current cycle the first ON cycle of a fresh period.
        always_comb begin
            eff_phase_s = phase_q;
            eff_cnt_s   = cnt_q;
            if (mode_s != mode_q) begin
                eff_phase_s = 1'b1;
                eff_cnt_s   = '0;
            end else begin
                eff_phase_s = phase_q;
                eff_cnt_s   = cnt_q;
            end
        end

        // Periodic phase next-state; outside periodic mode the phase parks at ON/0.
        always_comb begin
            phase_d = 1'b1;
            cnt_d   = '0;
            if (mode_s != MODE_PER) begin
                phase_d = 1'b1;
                cnt_d   = '0;
            end else if (off_s == '0) begin
                phase_d = 1'b1;
            end else if (on_s == '0) begin
                phase_d = 1'b0;
            end else if (eff_phase_s) begin
                if (eff_cnt_s >= on_s - CNT_W'(1)) begin
                    phase_d = 1'b0;
                end else begin
                    cnt_d = eff_cnt_s + CNT_W'(1);
                end
            end else begin
                if (eff_cnt_s >= off_s - CNT_W'(1)) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    cnt_d   = eff_cnt_s + CNT_W'(1);
                end
            end
        end

        // Gate decode from registered state and configuration only.
        always_comb begin
            raw_s = 1'b0;
            case (mode_s)
                MODE_BYP:  raw_s = 1'b1;
                MODE_RND:  raw_s = (lfsr_q[7:0] >= thr_s);
                MODE_PER:  raw_s = eff_phase_s;
                MODE_HALT: raw_s = 1'b0;
                default:   raw_s = 1'b0;
            endcase
        end

        assign allow_s = ~user_reset & (raw_s | lock_q);
        assign inc_s   = valid_i[c] & ready_i[c] & ~allow_s;
        assign lfsr_d  = lfsr_next(lfsr_q);
        // A presented beat stays locked open until it handshakes or upstream drops valid.
        assign lock_d  = valid_i[c] & allow_s & ~ready_i[c];

        // Saturating stall counter, clear wins over increment.
        always_comb begin
            stall_d = stall_q;
            if (stat_clr) begin
                stall_d = '0;
            end else if (inc_s && (stall_q != '1)) begin
                stall_d = stall_q + STAT_W'(1);
            end else begin
                stall_d = stall_q;
            end
        end

        // Channel state registers.
        always_ff @(posedge user_clk) begin
            if (user_reset) begin
                mode_q  <= mode_s;
                lfsr_q  <= chan_seed(c);
                phase_q <= 1'b1;
                cnt_q   <= '0;
                lock_q  <= 1'b0;
                stall_q <= '0;
            end else begin
                mode_q  <= mode_s;
                lfsr_q  <= lfsr_d;
                phase_q <= phase_d;
                cnt_q   <= cnt_d;
                lock_q  <= lock_d;
                stall_q <= stall_d;
            end
        end

        assign valid_o[c]                    = valid_i[c] & allow_s;
        assign ready_o[c]                    = ready_i[c] & allow_s;
        assign stall_cnt[STAT_W*c +: STAT_W] = user_reset ? '0 : stall_q;
    end

endmodule

// File: tb/tb_axis_bp_shaper.sv
// Directed bench for axis_bp_shaper: vector table plus multi-cycle corner sequences.
module tb_axis_bp_shaper;
    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int SW  = 8;
    localparam logic [31:0] SEED = 32'hb105f00d;

    logic              clk = 1'b0;
    logic              user_reset;
    logic [2*NCH-1:0]  mode;
    logic [8*NCH-1:0]  thresh;
    logic [CW*NCH-1:0] on_cnt, off_cnt;
    logic              stat_clr;
    logic [NCH-1:0]    valid_i, ready_i, valid_o, ready_o;
    logic [SW*NCH-1:0] stall_cnt;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] mdl [NCH];

    axis_bp_shaper #(.NUM_CH(NCH), .SEED(SEED), .CNT_W(CW), .STAT_W(SW)) dut (
        .user_clk(clk), .user_reset(user_reset), .mode(mode), .thresh(thresh),
        .on_cnt(on_cnt), .off_cnt(off_cnt), .stat_clr(stat_clr),
        .valid_i(valid_i), .ready_i(ready_i), .valid_o(valid_o), .ready_o(ready_o),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] md;
        logic [3:0] v, r, evo, ero;
    } vec_t;
    vec_t tv [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] seed_of(input int c);
        logic [31:0] x;
        x = SEED ^ (32'(c) * 32'h9E3779B9);
        return (x == 32'h0) ? SEED : x;
    endfunction

    function automatic logic [31:0] step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic logic [SW-1:0] stall_of(input int c);
        return stall_cnt[SW*c +: SW];
    endfunction

    task automatic next();
        @(posedge clk);
        for (int c = 0; c < NCH; c++) mdl[c] = step(mdl[c]);
        @(negedge clk);
    endtask

    task automatic do_reset();
        user_reset = 1'b1;
        #1;
        chk("rst_valid_o", 32'(valid_o), 32'h0);
        chk("rst_ready_o", 32'(ready_o), 32'h0);
        chk("rst_stall", stall_cnt, 32'h0);
        @(posedge clk);
        @(negedge clk);
        user_reset = 1'b0;
        for (int c = 0; c < NCH; c++) mdl[c] = seed_of(c);
    endtask

    // Random-mode expectation for one channel with valid/ready both high.
    task automatic chk_rand(input int c);
        logic exp;
        exp = (mdl[c][7:0] >= thresh[8*c +: 8]);
        chk($sformatf("rand_ch%0d", c), 32'(valid_o[c]), 32'(exp));
    endtask

    initial begin
        int blk;
        int k;
        user_reset = 1'b1; mode = '0; thresh = '0; on_cnt = '0; off_cnt = '0;
        stat_clr = 1'b0; valid_i = '0; ready_i = '0;
        for (int c = 0; c < NCH; c++) mdl[c] = seed_of(c);

        tv[0] = '{1'b1, 8'h00, 4'hF, 4'hF, 4'h0, 4'h0};
        tv[1] = '{1'b0, 8'h00, 4'hF, 4'hF, 4'hF, 4'hF};
        tv[2] = '{1'b0, 8'hFF, 4'hF, 4'hF, 4'h0, 4'h0};
        tv[3] = '{1'b0, 8'h00, 4'h5, 4'h3, 4'h5, 4'h3};
        tv[4] = '{1'b0, 8'hFF, 4'h5, 4'h0, 4'h4, 4'h0};
        tv[5] = '{1'b0, 8'hFF, 4'h4, 4'h4, 4'h4, 4'h4};
        tv[6] = '{1'b0, 8'hFF, 4'hF, 4'hF, 4'h0, 4'h0};
        tv[7] = '{1'b0, 8'hFC, 4'hF, 4'hF, 4'h1, 4'h1};
        tv[8] = '{1'b1, 8'h00, 4'hF, 4'hF, 4'h0, 4'h0};

        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            user_reset = tv[i].rst; mode = tv[i].md; valid_i = tv[i].v; ready_i = tv[i].r;
            #1;
            chk($sformatf("tv%0d_valid_o", i), 32'(valid_o), 32'(tv[i].evo));
            chk($sformatf("tv%0d_ready_o", i), 32'(ready_o), 32'(tv[i].ero));
            if (tv[i].rst) chk($sformatf("tv%0d_stall", i), stall_cnt, 32'h0);
            next();
        end

        // Bypass on every channel for 100 cycles.
        mode = 8'h00; valid_i = 4'hF; ready_i = 4'hF;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            #1;
            chk("byp_valid_o", 32'(valid_o), 32'hF);
            chk("byp_ready_o", 32'(ready_o), 32'hF);
            next();
        end
        chk("byp_stall", stall_cnt, 32'h0);

        // Periodic 3 on / 2 off on ch0.
        mode = 8'h02; on_cnt = 32'h3; off_cnt = 32'h2;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            #1;
            chk("per_valid_o0", 32'(valid_o[0]), 32'((i % 5) < 3));
            chk("per_ready_o0", 32'(ready_o[0]), 32'((i % 5) < 3));
            next();
        end
        chk("per_stall0", 32'(stall_of(0)), 32'd40);

        // Random mode on all channels against an LFSR model.
        mode = 8'h55; thresh = 32'h80808080; on_cnt = '0; off_cnt = '0;
        do_reset();
        blk = 0;
        for (int i = 0; i < 2000; i++) begin
            #1;
            for (int c = 0; c < NCH; c++) chk_rand(c);
            if (!valid_o[1]) blk++;
            next();
        end
        chk("rand_frac_ok", 32'((blk >= 900) && (blk <= 1100)), 32'h1);
        thresh[15:8] = 8'd0; stat_clr = 1'b1;
        next();
        stat_clr = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            chk_rand(1);
            next();
        end
        chk("rand_t0_stall1", 32'(stall_of(1)), 32'h0);
        thresh[15:8] = 8'd255;
        k = 0;
        for (int i = 0; i < 1024; i++) begin
            #1;
            chk_rand(1);
            if (valid_o[1]) k++;
            next();
        end
        chk("rand_t255_rare", 32'(k <= 16), 32'h1);

        // Pending beat on ch2 survives a switch to halt, then halt bites.
        mode = 8'h00; thresh = '0; valid_i = 4'b0100; ready_i = 4'b0000;
        do_reset();
        #1; chk("lock_v0", 32'(valid_o[2]), 32'h1);
        next();
        mode = 8'h30;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("lock_hold_v", 32'(valid_o[2]), 32'h1);
            chk("lock_hold_r", 32'(ready_o[2]), 32'h0);
            next();
        end
        ready_i = 4'b0100;
        #1;
        chk("lock_hs_v", 32'(valid_o[2]), 32'h1);
        chk("lock_hs_r", 32'(ready_o[2]), 32'h1);
        next();
        #1;
        chk("halt_v", 32'(valid_o[2]), 32'h0);
        chk("halt_r", 32'(ready_o[2]), 32'h0);
        next();
        #1; chk("halt_stall2", 32'(stall_of(2)), 32'h1);

        // Saturation and clear priority on ch3.
        mode = 8'hC0; valid_i = 4'hF; ready_i = 4'hF;
        do_reset();
        for (int i = 0; i < 255; i++) next();
        #1; chk("sat_255", 32'(stall_of(3)), 32'd255);
        for (int i = 0; i < 5; i++) next();
        #1; chk("sat_hold", 32'(stall_of(3)), 32'd255);
        chk("sat_other0", 32'(stall_of(0)), 32'h0);
        stat_clr = 1'b1;
        next();
        stat_clr = 1'b0;
        #1; chk("clr_zero", 32'(stall_of(3)), 32'h0);
        next();
        #1; chk("clr_restart", 32'(stall_of(3)), 32'h1);

        // Reset in OFF phase with a lock held; state must restart cleanly.
        mode = 8'h06; thresh = 32'h00008000; on_cnt = 32'h3; off_cnt = 32'h2;
        valid_i = 4'hF; ready_i = 4'hF;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ready_i = (i == 2) ? 4'b1110 : 4'hF;
            #1;
            chk("mid_on_v0", 32'(valid_o[0]), 32'h1);
            chk_rand(1);
            next();
        end
        ready_i = 4'b1110;
        #1;
        chk("mid_lock_v0", 32'(valid_o[0]), 32'h1);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            valid_i = (i < 3) ? 4'b1110 : 4'hF;
            ready_i = (i == 3) ? 4'b1110 : 4'hF;
            #1;
            if (i < 3) chk("post_on_r0", 32'(ready_o[0]), 32'h1);
            if (i == 3) chk("post_nolock_v0", 32'(valid_o[0]), 32'h0);
            if (i == 4) chk("post_off_r0", 32'(ready_o[0]), 32'h0);
            if (i == 5) chk("post_on2_r0", 32'(ready_o[0]), 32'h1);
            chk_rand(1);
            next();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/axis_bp_shaper.md
Name: axis_bp_shaper

Overview:
- Parametrised, multi-channel successor to the AXIS backpressure throttle.
- Sits between traffic generators and CPM5N CSI fabric interfaces, one channel per valid/ready pair, and injects programmable backpressure for stress testing.
- Adds per-channel mode select (bypass / random with programmable probability / periodic on-off / halt), independent per-channel LFSRs and protocol-safe gating: an asserted valid_o is never withdrawn before its handshake completes.
- Adds per-channel saturating stall counters.

Parameters:
- NUM_CH, 8, number of independent valid/ready channels (1..32).
- SEED, 32'hb105f00d, base LFSR seed.
- CNT_W, 16, width of the periodic on/off count fields.
- STAT_W, 32, width of each stall counter.

Ports:
- user_clk  in  1  sole clock.
- user_reset  in  1  synchronous, active-high reset.
- mode  in  2*NUM_CH  per channel: 00 bypass, 01 random, 10 periodic, 11 halt.
- thresh  in  8*NUM_CH  random mode: block probability = thresh/256.
- on_cnt  in  CNT_W*NUM_CH  periodic mode: allow-phase length in cycles.
- off_cnt  in  CNT_W*NUM_CH  periodic mode: block-phase length in cycles.
- stat_clr  in  1  synchronous clear of all stall counters.
- valid_i  in  NUM_CH  upstream valid.
- ready_i  in  NUM_CH  downstream ready.
- valid_o  out  NUM_CH  gated valid to downstream.
- ready_o  out  NUM_CH  gated ready to upstream.
- stall_cnt  out  STAT_W*NUM_CH  per-channel count of cycles blocked by this block.

Behaviour:
- Channel c gating signal allow[c]:
  - valid_o[c] = valid_i[c] & allow[c]
  - ready_o[c] = ready_i[c] & allow[c]
  - Combinational, zero latency. allow is derived from registered state only (no combinational path from valid/ready to allow).
- Reset: while user_reset=1, allow=0 for all channels, so valid_o=0, ready_o=0 and stall_cnt=0. All internal state is set to its reset value: lfsr, phase=ON, phase count=0, lock=0.
- Per-channel LFSR:
  - 32-bit Galois, taps x^32+x^22+x^2+x+1, advances every cycle.
  - Reset seed = SEED ^ (c*32'h9E3779B9). If that value is zero, seed = SEED.
- raw_allow by mode:
  - 00: 1.
  - 01: lfsr[7:0] >= thresh. thresh=0 gives always allow.
  - 10: 1 in ON phase, 0 in OFF phase.
  - 11: 0.
- Periodic phasing:
  - Phase counter counts cycles in the current phase and switches phase when count reaches on_cnt-1 (ON) or off_cnt-1 (OFF), then count returns to 0.
  - off_cnt=0: permanently ON.
  - on_cnt=0 with off_cnt!=0: permanently OFF.
  - Both zero: ON.
- Any change of mode[c] (registered compare) restarts channel c at ON phase, count 0. The LFSR is unaffected.
- Protocol-safe lock:
  - lock[c] sets when valid_o[c]=1 and ready_i[c]=0.
  - lock[c] clears on handshake (valid_i & ready_i & allow).
  - allow[c] = raw_allow[c] | lock[c].
  - Halt (11) also honours lock: it takes effect after any pending beat completes.
  - If valid_i[c] is withdrawn by upstream while locked, lock clears the next cycle. This is an upstream violation, not flagged.
- Stall counting:
  - stall_cnt[c] increments when valid_i[c]=1, ready_i[c]=1 and allow[c]=0.
  - Saturates at all-ones; does not wrap.
  - stat_clr has priority: a clear in the same cycle as an increment yields 0.
- Channels are fully independent; config inputs are sampled every cycle and are not latched.
- Reset asserted mid-transfer: outputs drop to 0 immediately in the reset cycle and lock is cleared.

Test Plan:
- All modes 00, valid_i=ready_i=all-ones for 100 cycles -> valid_o=ready_o=all-ones every cycle; stall_cnt=0.
- Ch0 mode 10, on_cnt=3, off_cnt=2, valid/ready held high -> allow pattern 1,1,1,0,0 repeating; stall_cnt[0]=40 after 100 cycles.
- Ch1 mode 01, thresh=128, 65536 cycles, valid/ready high -> blocked fraction 0.5±0.02. thresh=0 -> stall_cnt[1]=0. thresh=255 -> at most 1 handshake per 128 cycles on average.
- Ch2 valid_i=1, ready_i=0 while allowed, then mode switched to 11 -> valid_o[2] stays 1 until ready_i rises; one handshake occurs, then valid_o=ready_o=0 from the next cycle.
- STAT_W=4, ch3 mode 11, valid/ready high for 20 cycles -> stall_cnt[3] saturates at 15. stat_clr pulsed on an incrementing cycle -> 0 next cycle.
- Assert user_reset for 1 cycle mid periodic OFF phase with lock set -> outputs 0 during reset; afterwards ON phase, count 0, lock 0, LFSRs back at seed (identical sequence to the first run).
